// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: single-button sequencer for the stopwatch counter.
// A short press toggles STOP/RUN, a long press clears. In RUN a periodic
// one-cycle count enable is produced for the BCD time counter.
module stopwatch_ctrl #(
  parameter int TICK_DIV    = 500000,
  parameter int HOLD_CYCLES = 100000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic [1:0] o_state,
  output logic       o_run,
  output logic       o_clear,
  output logic       o_tick,
  output logic       o_held
);

  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    ST_STOP  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                btn_q;
  logic                btn_p;
  logic                smp_q;
  logic                smp_p;
  logic                armed;
  logic                held;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [PRE_W-1:0]    pre_cnt;

  logic rise;
  logic fall;
  logic long_evt;
  logic short_evt;

  // A rise only counts when btn_p holds a genuine sample; right after reset
  // btn_p is a forced zero, so a button held through reset cannot arm.
  assign rise      = btn_q & ~btn_p & smp_p;
  assign fall      = ~btn_q & btn_p;
  // The counter saturating at HOLD_MAX while armed is the long press; it is
  // acted on one edge after the counter reaches HOLD_MAX.
  assign long_evt  = armed & (hold_cnt == HOLD_MAX);
  assign short_evt = fall & armed;

  // Two-stage button sampler plus flags marking which stages hold real samples
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      btn_q <= 1'b0;
      btn_p <= 1'b0;
      smp_q <= 1'b0;
      smp_p <= 1'b0;
    end else begin
      btn_q <= i_btn;
      btn_p <= btn_q;
      smp_q <= 1'b1;
      smp_p <= smp_q;
    end
  end

  // Arm on a qualified press, disarm on release or once the long press is taken
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed <= 1'b0;
    end else if (long_evt || fall) begin
      armed <= 1'b0;
    end else if (rise) begin
      armed <= 1'b1;
    end
  end

  // Hold timer; counts from the first pressed sample of an armed press
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_cnt <= '0;
    end else if (!btn_q || !(armed || rise)) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Held flag: set by the long press, dropped once the button reads released
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      held <= 1'b0;
    end else if (long_evt) begin
      held <= 1'b1;
    end else if (!btn_q) begin
      held <= 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; long press wins over a coincident short press.
  // CLEAR leaves as soon as the button reads released, which also covers a
  // release landing on the same edge as the long press.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if (long_evt)       state_nxt = ST_CLEAR;
        else if (short_evt) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (long_evt)       state_nxt = ST_CLEAR;
        else if (short_evt) state_nxt = ST_STOP;
      end
      ST_CLEAR: begin
        if (!btn_q)         state_nxt = ST_STOP;
      end
      default: state_nxt = ST_STOP;
    endcase
  end

  // Tick prescaler: runs in RUN, freezes in STOP to keep phase, zeroed in CLEAR
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pre_cnt <= '0;
    end else begin
      case (state)
        ST_RUN:   pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
        ST_CLEAR: pre_cnt <= '0;
        default:  pre_cnt <= pre_cnt;
      endcase
    end
  end

  assign o_state = state;
  assign o_run   = (state == ST_RUN);
  assign o_clear = (state == ST_CLEAR);
  assign o_tick  = (state == ST_RUN) && (pre_cnt == PRE_LAST);
  assign o_held  = held;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with TICK_DIV=4,
// HOLD_CYCLES=8. Inputs change and outputs are sampled on the falling edge;
// each expectation covers one clock cycle, numbered in the comments.
module tb_stopwatch_ctrl;

  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] R = 2'b10;
  localparam logic [1:0] C = 2'b01;

  logic       i_clk;
  logic       i_rst;
  logic       i_btn;
  logic [1:0] o_state;
  logic       o_run;
  logic       o_clear;
  logic       o_tick;
  logic       o_held;

  int errors = 0;
  int checks = 0;

  stopwatch_ctrl #(
    .TICK_DIV    (4),
    .HOLD_CYCLES (8)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_btn   (i_btn),
    .o_state (o_state),
    .o_run   (o_run),
    .o_clear (o_clear),
    .o_tick  (o_tick),
    .o_held  (o_held)
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Drive button and reset levels for the coming rising edge
  task automatic applyStimulus(input logic btn, input logic rst);
    i_btn = btn;
    i_rst = rst;
  endtask

  // Single comparison point: counts and reports a mismatch
  task automatic checkOutput(input string tag, input logic [5:0] observed,
                             input logic [5:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got {state,run,clear,tick,held}=%b expected %b at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Check n consecutive cycles against one expected state/tick/held, then advance
  task automatic expectCycles(input string tag, input int n, input logic [1:0] st,
                              input logic tk, input logic hd);
    logic [5:0] exp_v;
    exp_v = {st, (st == 2'b10), (st == 2'b01), tk, hd};
    for (int i = 0; i < n; i++) begin
      checkOutput(tag, {o_state, o_run, o_clear, o_tick, o_held}, exp_v);
      @(negedge i_clk);
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b1);
    @(negedge i_clk);
    @(negedge i_clk);

    // Reset state, then a button held through reset must be ignored
    expectCycles("reset", 1, S, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    expectCycles("rst_btn_held", 2, S, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    expectCycles("held_after_rst", 12, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("release_unarmed", 4, S, 1'b0, 1'b0);

    // Three-cycle press: RUN on the second edge after release
    applyStimulus(1'b1, 1'b0);
    expectCycles("press3", 3, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("release_wait", 2, S, 1'b0, 1'b0);
    // c1..c11 in RUN, prescaler starts from zero
    expectCycles("run_p0", 3, R, 1'b0, 1'b0);
    expectCycles("tick_p0", 1, R, 1'b1, 1'b0);
    expectCycles("run_p1", 3, R, 1'b0, 1'b0);
    expectCycles("tick_p1", 1, R, 1'b1, 1'b0);
    expectCycles("run_p2", 3, R, 1'b0, 1'b0);

    // c12: tick cycle, start a one-cycle pause press; STOP from c15 with prescaler 2
    applyStimulus(1'b1, 1'b0);
    expectCycles("tick_at_press", 1, R, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("run_releasing", 2, R, 1'b0, 1'b0);
    expectCycles("paused", 4, S, 1'b0, 1'b0);
    // c19: resume press; RUN from c22, tick at c23 thanks to preserved phase
    applyStimulus(1'b1, 1'b0);
    expectCycles("resume_press", 1, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("resume_release", 2, S, 1'b0, 1'b0);
    expectCycles("resumed", 1, R, 1'b0, 1'b0);
    expectCycles("phase_tick", 1, R, 1'b1, 1'b0);

    // c24: 20-cycle press in RUN; CLEAR from c34 (edge j+9)
    applyStimulus(1'b1, 1'b0);
    expectCycles("long_run_a", 3, R, 1'b0, 1'b0);
    expectCycles("long_tick_a", 1, R, 1'b1, 1'b0);
    expectCycles("long_run_b", 3, R, 1'b0, 1'b0);
    expectCycles("long_tick_b", 1, R, 1'b1, 1'b0);
    expectCycles("long_run_c", 2, R, 1'b0, 1'b0);
    expectCycles("clear_held", 10, C, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    expectCycles("clear_release", 2, C, 1'b0, 1'b1);
    // c46: STOP; short press gives first tick a full period later (c52)
    applyStimulus(1'b1, 1'b0);
    expectCycles("after_clear", 1, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("after_clear_rel", 2, S, 1'b0, 1'b0);
    expectCycles("fresh_run", 3, R, 1'b0, 1'b0);
    expectCycles("fresh_tick", 1, R, 1'b1, 1'b0);

    // c53: seven-cycle press in RUN only toggles to STOP
    applyStimulus(1'b1, 1'b0);
    expectCycles("p7_run", 3, R, 1'b0, 1'b0);
    expectCycles("p7_tick", 1, R, 1'b1, 1'b0);
    expectCycles("p7_run_b", 3, R, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("p7_tick_b", 1, R, 1'b1, 1'b0);
    expectCycles("p7_last_run", 1, R, 1'b0, 1'b0);
    expectCycles("p7_stop", 2, S, 1'b0, 1'b0);
    // c64: eight-cycle press from STOP clears, release gives no toggle
    applyStimulus(1'b1, 1'b0);
    expectCycles("p8_press", 8, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("p8_release", 2, S, 1'b0, 1'b0);
    expectCycles("p8_clear", 1, C, 1'b0, 1'b1);
    expectCycles("p8_no_toggle", 2, S, 1'b0, 1'b0);

    // c77: long press into CLEAR, then reset while the button stays held
    applyStimulus(1'b1, 1'b0);
    expectCycles("p6_press", 10, S, 1'b0, 1'b0);
    expectCycles("p6_clear", 1, C, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    expectCycles("p6_rst_edge", 1, C, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0);
    expectCycles("p6_after_rst", 1, S, 1'b0, 1'b0);
    expectCycles("p6_no_reentry", 20, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("p6_release", 3, S, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    expectCycles("p6_short", 1, S, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    expectCycles("p6_short_rel", 2, S, 1'b0, 1'b0);
    expectCycles("p6_run", 3, R, 1'b0, 1'b0);
    expectCycles("p6_tick", 1, R, 1'b1, 1'b0);
    expectCycles("p6_run_b", 1, R, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
